// File: rtl/delay_meas_pkg.sv
// Shared definitions for the delay-line launch/capture meter: state encoding and
// default parameter values.
package delay_meas_pkg;

  localparam int unsigned CntWDefault       = 16;
  localparam int unsigned TimeoutDefault    = 4096;
  localparam int unsigned SyncStagesDefault = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/delay_sync.sv
// Multi-flop synchronizer that brings the asynchronous chain output into the clk domain.
module delay_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/path_delay_meter.sv
// Launches alternating edges into the delay chain and counts clk cycles until each edge
// returns through the synchronizer; results leave through a valid/ready handshake.
module path_delay_meter
  import delay_meas_pkg::*;
#(
  parameter int unsigned CNT_W       = CntWDefault,
  parameter int unsigned TIMEOUT     = TimeoutDefault,
  parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  output logic             o_ready,
  output logic             o_path_input,
  input  logic             i_path_result,
  output logic             o_result_valid,
  input  logic             i_result_ready,
  output logic [CNT_W-1:0] o_result_count,
  output logic             o_result_timeout,
  output logic             o_result_edge
);

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_result_count;
  logic             r_path_input;
  logic             r_result_valid;
  logic             r_result_timeout;
  logic             r_result_edge;
  logic             w_sync_q;
  logic             w_arrived;
  logic [CNT_W-1:0] w_cnt_inc;

  delay_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (i_path_result),
    .o_q    (w_sync_q)
  );

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_arrived = (w_sync_q == r_path_input);
  assign o_ready   = (r_state == StIdle) && w_arrived;

  // Arrival is seen on the registered sync_q one edge after it changed, so r_cnt already
  // holds the number of edges up to and including that change.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= StIdle;
      r_cnt            <= '0;
      r_path_input     <= 1'b0;
      r_result_valid   <= 1'b0;
      r_result_count   <= '0;
      r_result_timeout <= 1'b0;
      r_result_edge    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_start && o_ready) begin
            r_path_input  <= ~r_path_input;
            r_result_edge <= ~r_path_input;
            r_cnt         <= '0;
            r_state       <= StWait;
          end
        end
        StWait: begin
          r_cnt <= w_cnt_inc;
          if (w_arrived) begin
            r_result_count   <= r_cnt;
            r_result_timeout <= 1'b0;
            r_result_valid   <= 1'b1;
            r_state          <= StDone;
          end else if (w_cnt_inc == TimeoutCnt) begin
            r_result_count   <= TimeoutCnt;
            r_result_timeout <= 1'b1;
            r_result_valid   <= 1'b1;
            r_state          <= StDone;
          end
        end
        StDone: begin
          if (i_result_ready) begin
            r_result_valid <= 1'b0;
            r_state        <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_path_input     = r_path_input;
  assign o_result_valid   = r_result_valid;
  assign o_result_count   = r_result_count;
  assign o_result_timeout = r_result_timeout;
  assign o_result_edge    = r_result_edge;

endmodule

// File: tb/tb_path_delay_meter.sv
// Directed bench for path_delay_meter: loopback, 7-cycle chain, dead chain with short
// timeout, back-pressure, start held high and reset during a measurement.
module tb_path_delay_meter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        ready;
  logic        path_input;
  logic        path_result;
  logic        valid;
  logic        result_ready;
  logic [15:0] count;
  logic        tmo;
  logic        res_edge;
  logic        mode;
  logic [6:0]  dly = '0;

  logic        start_b;
  logic        ready_b;
  logic        path_input_b;
  logic        path_result_b;
  logic        valid_b;
  logic        result_ready_b;
  logic [15:0] count_b;
  logic        tmo_b;
  logic        res_edge_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Chain model: mode 0 = zero-delay loopback, mode 1 = 7-cycle delay line.
  always @(posedge clk) dly <= {dly[5:0], path_input};
  assign path_result   = mode ? dly[6] : path_input;
  assign path_result_b = 1'b0;

  path_delay_meter #(
    .CNT_W      (16),
    .TIMEOUT    (4096),
    .SYNC_STAGES(2)
  ) u_dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_start         (start),
    .o_ready         (ready),
    .o_path_input    (path_input),
    .i_path_result   (path_result),
    .o_result_valid  (valid),
    .i_result_ready  (result_ready),
    .o_result_count  (count),
    .o_result_timeout(tmo),
    .o_result_edge   (res_edge)
  );

  path_delay_meter #(
    .CNT_W      (16),
    .TIMEOUT    (20),
    .SYNC_STAGES(2)
  ) u_dut_to (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_start         (start_b),
    .o_ready         (ready_b),
    .o_path_input    (path_input_b),
    .i_path_result   (path_result_b),
    .o_result_valid  (valid_b),
    .i_result_ready  (result_ready_b),
    .o_result_count  (count_b),
    .o_result_timeout(tmo_b),
    .o_result_edge   (res_edge_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_launch", {31'd0, ready}, 32'd1);
  endtask

  // Returns on the negedge right after the launch edge.
  task automatic launch();
    wait_ready();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int limit);
    int n;
    n = 0;
    while (valid !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("result_valid_arrives", {31'd0, valid}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_low;
    rst_n          = 1'b0;
    start          = 1'b0;
    result_ready   = 1'b1;
    mode           = 1'b0;
    start_b        = 1'b0;
    result_ready_b = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_path_input", {31'd0, path_input}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_count", {16'd0, count}, 32'd0);
    chk("rst_timeout", {31'd0, tmo}, 32'd0);
    chk("rst_edge", {31'd0, res_edge}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1. Loopback, two launches
    launch();
    chk("t1a_path_input", {31'd0, path_input}, 32'd1);
    chk("t1a_ready_in_flight", {31'd0, ready}, 32'd0);
    wait_valid(50);
    chk("t1a_count", {16'd0, count}, 32'd2);
    chk("t1a_timeout", {31'd0, tmo}, 32'd0);
    chk("t1a_edge", {31'd0, res_edge}, 32'd1);
    @(negedge clk);
    chk("t1a_valid_taken", {31'd0, valid}, 32'd0);
    chk("t1a_ready_again", {31'd0, ready}, 32'd1);
    launch();
    chk("t1b_path_input", {31'd0, path_input}, 32'd0);
    wait_valid(50);
    chk("t1b_count", {16'd0, count}, 32'd2);
    chk("t1b_edge", {31'd0, res_edge}, 32'd0);
    chk("t1b_timeout", {31'd0, tmo}, 32'd0);
    @(negedge clk);

    // 4. Back-pressure: result held while result_ready is low
    result_ready = 1'b0;
    launch();
    wait_valid(50);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_valid_held", {31'd0, valid}, 32'd1);
      chk("t4_count_held", {16'd0, count}, 32'd2);
      chk("t4_edge_held", {31'd0, res_edge}, 32'd1);
      chk("t4_timeout_held", {31'd0, tmo}, 32'd0);
    end
    result_ready = 1'b1;
    @(negedge clk);
    chk("t4_valid_drop", {31'd0, valid}, 32'd0);
    chk("t4_count_kept", {16'd0, count}, 32'd2);

    // 6. start held high through WAIT and DONE
    result_ready = 1'b0;
    wait_ready();
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_single_toggle", {31'd0, path_input}, 32'd0);
    end
    chk("t6_valid", {31'd0, valid}, 32'd1);
    chk("t6_edge", {31'd0, res_edge}, 32'd0);
    start        = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    chk("t6_valid_drop", {31'd0, valid}, 32'd0);
    chk("t6_no_relaunch", {31'd0, path_input}, 32'd0);

    // 5. Reset in cycle 3 of WAIT on the 7-cycle chain
    mode = 1'b1;
    repeat (10) @(negedge clk);
    launch();
    chk("t5_path_input", {31'd0, path_input}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_path_input", {31'd0, path_input}, 32'd0);
    chk("t5_rst_valid", {31'd0, valid}, 32'd0);
    chk("t5_rst_edge", {31'd0, res_edge}, 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    saw_low = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ready === 1'b0) saw_low = 1'b1;
    end
    chk("t5_ready_gated_stray_edge", {31'd0, saw_low}, 32'd1);
    chk("t5_ready_returns", {31'd0, ready}, 32'd1);
    chk("t5_no_launch", {31'd0, path_input}, 32'd0);

    // 2. 7-cycle chain
    launch();
    wait_valid(50);
    chk("t2_count", {16'd0, count}, 32'd9);
    chk("t2_timeout", {31'd0, tmo}, 32'd0);
    chk("t2_edge", {31'd0, res_edge}, 32'd1);
    @(negedge clk);

    // 3. Dead chain, TIMEOUT=20
    chk("t3_ready_idle", {31'd0, ready_b}, 32'd1);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("t3_path_input", {31'd0, path_input_b}, 32'd1);
    repeat (19) @(negedge clk);
    chk("t3_valid_not_early", {31'd0, valid_b}, 32'd0);
    @(negedge clk);
    chk("t3_valid_at_timeout", {31'd0, valid_b}, 32'd1);
    chk("t3_count", {16'd0, count_b}, 32'd20);
    chk("t3_timeout", {31'd0, tmo_b}, 32'd1);
    chk("t3_edge", {31'd0, res_edge_b}, 32'd1);
    result_ready_b = 1'b1;
    @(negedge clk);
    chk("t3_valid_taken", {31'd0, valid_b}, 32'd0);
    repeat (5) @(negedge clk);
    chk("t3_ready_stays_low", {31'd0, ready_b}, 32'd0);
    chk("t3_fields_kept", {16'd0, count_b}, 32'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
